time_keeper: RTL and testbench

Local time-of-day counter that produces the hr/min/sec values consumed by the PC104 clock-sync stage, and accepts the synced remote time back from it.
- Periodically raises the sync request that starts a time-sync phase.
- Loads the remote time when the sync stage pulses done.
- Supports manual hour/minute adjust pulses from the front panel.

---
 rtl/clock_pkg.sv | 29 ++
 rtl/time_keeper_if.sv | 33 +++
 rtl/tick_prescaler.sv | 39 +++
 rtl/time_keeper.sv | 141 ++++++++++++++
 tb/tb_time_keeper.sv | 259 +++++++++++++++++++++++++
 5 files changed

// File: rtl/clock_pkg.sv
// Shared time-of-day definitions for the local time keeper and the PC104 clock-sync stage.
// Provides field widths, field maxima, the sync FSM state type and the packed hr/min/sec payload.
package clock_pkg;

   localparam int unsigned HR_W  = 5;
   localparam int unsigned MIN_W = 6;
   localparam int unsigned SEC_W = 6;

   localparam logic [HR_W-1:0]  HR_MAX  = HR_W'(23);
   localparam logic [MIN_W-1:0] MIN_MAX = MIN_W'(59);
   localparam logic [SEC_W-1:0] SEC_MAX = SEC_W'(59);

   typedef enum logic {
      IDLE     = 1'b0,
      REQ_WAIT = 1'b1
   } sync_state_e;

   typedef struct packed {
      logic [HR_W-1:0]  hr;
      logic [MIN_W-1:0] min;
      logic [SEC_W-1:0] sec;
   } tod_t;

   // True when every field of a time value is inside its legal range.
   function automatic logic tod_valid(tod_t t);
      return (t.hr <= HR_MAX) && (t.min <= MIN_MAX) && (t.sec <= SEC_MAX);
   endfunction

endpackage

// File: rtl/time_keeper_if.sv
// Bus between the time keeper and its environment (sync stage + front panel).
// master: drives sync_done/sync_hr/sync_min/sync_sec and inc_hr/inc_min, observes time/status.
// slave : the time keeper; consumes the load/adjust inputs, drives hr/min/sec, sec_tick,
//         request, sync_fail and load_err.
interface time_keeper_if;
   import clock_pkg::*;

   logic             sync_done;
   logic [HR_W-1:0]  sync_hr;
   logic [MIN_W-1:0] sync_min;
   logic [SEC_W-1:0] sync_sec;
   logic             inc_hr;
   logic             inc_min;

   logic [HR_W-1:0]  hr;
   logic [MIN_W-1:0] min;
   logic [SEC_W-1:0] sec;
   logic             sec_tick;
   logic             request;
   logic             sync_fail;
   logic             load_err;

   modport master (
      output sync_done, sync_hr, sync_min, sync_sec, inc_hr, inc_min,
      input  hr, min, sec, sec_tick, request, sync_fail, load_err
   );

   modport slave (
      input  sync_done, sync_hr, sync_min, sync_sec, inc_hr, inc_min,
      output hr, min, sec, sec_tick, request, sync_fail, load_err
   );

endinterface

// File: rtl/tick_prescaler.sv
// Divides the system clock down to a one-second tick.
// Ports: clock, reset (sync, active-high), clear (restart the second from zero),
//        tick (high in the cycle the count sits at CLK_DIV-1; suppressed while clear is high).
module tick_prescaler #(
   parameter int unsigned CLK_DIV = 50_000_000
) (
   input  logic clock,
   input  logic reset,
   input  logic clear,
   output logic tick
);

   localparam int unsigned CNT_W = $clog2(CLK_DIV);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             wrap_c;

   assign wrap_c = (cnt_q == CNT_W'(CLK_DIV - 1));
   // A clear restarts the second, so the tick that would have landed with it is dropped.
   assign tick   = wrap_c && !clear;

   // Next count: wrap at the top or restart on clear.
   always_comb begin
      cnt_d = cnt_q + CNT_W'(1);
      if (clear || wrap_c) begin
         cnt_d = '0;
      end
   end

   // Count register.
   always_ff @(posedge clock) begin
      if (reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/time_keeper.sv
// Local time-of-day counter feeding the PC104 clock-sync stage.
// Ports: clock, reset (sync, active-high), tk (time_keeper_if.slave):
//   in : sync_done + sync_hr/min/sec (remote time load), inc_hr/inc_min (panel adjust)
//   out: hr/min/sec, sec_tick, request (sync outstanding), sync_fail, load_err; all registered.
module time_keeper
   import clock_pkg::*;
#(
   parameter int unsigned CLK_DIV        = 50_000_000,
   parameter int unsigned SYNC_PERIOD_S  = 3600,
   parameter int unsigned SYNC_TIMEOUT_S = 5
) (
   input  logic          clock,
   input  logic          reset,
   time_keeper_if.slave  tk
);

   localparam int unsigned CNT_MAX = (SYNC_PERIOD_S > SYNC_TIMEOUT_S) ? SYNC_PERIOD_S : SYNC_TIMEOUT_S;
   localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

   sync_state_e      state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc_c;
   tod_t             tod_q, tod_d, sync_tod_c;
   logic             sec_tick_q, request_q, request_d;
   logic             fail_q, fail_d, load_err_q;
   logic             load_ok_c, load_bad_c, tick_c;

   assign sync_tod_c = {tk.sync_hr, tk.sync_min, tk.sync_sec};
   assign load_ok_c  = tk.sync_done && tod_valid(sync_tod_c);
   assign load_bad_c = tk.sync_done && !tod_valid(sync_tod_c);
   assign cnt_inc_c  = cnt_q + CNT_W'(1);

   // Second prescaler; a valid load restarts the second so the loaded sec lasts a full second.
   tick_prescaler #(
      .CLK_DIV (CLK_DIV)
   ) u_prescaler (
      .clock (clock),
      .reset (reset),
      .clear (load_ok_c),
      .tick  (tick_c)
   );

   // Time update: a valid load overrides everything; otherwise tick first, then adjusts on top.
   // An out-of-range load is ignored for time purposes and only raises load_err.
   always_comb begin
      tod_d = tod_q;
      if (load_ok_c) begin
         tod_d = sync_tod_c;
      end else begin
         if (tick_c) begin
            if (tod_q.sec == SEC_MAX) begin
               tod_d.sec = '0;
               if (tod_q.min == MIN_MAX) begin
                  tod_d.min = '0;
                  tod_d.hr  = (tod_q.hr == HR_MAX) ? '0 : tod_q.hr + HR_W'(1);
               end else begin
                  tod_d.min = tod_q.min + MIN_W'(1);
               end
            end else begin
               tod_d.sec = tod_q.sec + SEC_W'(1);
            end
         end
         if (tk.inc_min) begin
            tod_d.min = (tod_d.min == MIN_MAX) ? '0 : tod_d.min + MIN_W'(1);
         end
         if (tk.inc_hr) begin
            tod_d.hr = (tod_d.hr == HR_MAX) ? '0 : tod_d.hr + HR_W'(1);
         end
      end
   end

   // Sync FSM: period count in IDLE, timeout count in REQ_WAIT; a valid load always restarts it.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      fail_d    = 1'b0;
      case (state_q)
         IDLE: begin
            if (load_ok_c) begin
               cnt_d = '0;
            end else if (tick_c) begin
               if (cnt_inc_c == CNT_W'(SYNC_PERIOD_S)) begin
                  state_d = REQ_WAIT;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_inc_c;
               end
            end
         end
         REQ_WAIT: begin
            // load_ok_c suppresses tick_c, so a load can never coincide with a timeout here.
            if (load_ok_c) begin
               state_d = IDLE;
               cnt_d   = '0;
            end else if (tick_c) begin
               if (cnt_inc_c == CNT_W'(SYNC_TIMEOUT_S)) begin
                  state_d = IDLE;
                  cnt_d   = '0;
                  fail_d  = 1'b1;
               end else begin
                  cnt_d = cnt_inc_c;
               end
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase
      request_d = (state_d == REQ_WAIT);
   end

   // State and output registers.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         tod_q      <= '0;
         sec_tick_q <= 1'b0;
         request_q  <= 1'b0;
         fail_q     <= 1'b0;
         load_err_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         tod_q      <= tod_d;
         sec_tick_q <= tick_c;
         request_q  <= request_d;
         fail_q     <= fail_d;
         load_err_q <= load_bad_c;
      end
   end

   assign tk.hr        = tod_q.hr;
   assign tk.min       = tod_q.min;
   assign tk.sec       = tod_q.sec;
   assign tk.sec_tick  = sec_tick_q;
   assign tk.request   = request_q;
   assign tk.sync_fail = fail_q;
   assign tk.load_err  = load_err_q;

endmodule

// File: tb/tb_time_keeper.sv
// Scoreboard bench for time_keeper (CLK_DIV=4, SYNC_PERIOD_S=10, SYNC_TIMEOUT_S=3).
// Stimulus tasks push expected output events (kind, cycle, time) into a queue; a negedge
// monitor pops one entry per event the DUT presents and compares. Static values after
// resets, loads and adjusts are compared directly.
module tb_time_keeper;
   import clock_pkg::*;

   typedef enum int {EV_REQ_RISE, EV_REQ_FALL, EV_FAIL, EV_LERR, EV_TICK} ev_kind_e;
   typedef struct {
      ev_kind_e kind;
      int       cyc;
      int       hr;
      int       mn;
      int       sc;
   } ev_t;

   ev_t  exp_q[$];
   logic clk = 1'b0;
   logic reset;
   int   cyc = 0;
   int   n_pass = 0;
   int   n_checks = 0;
   bit   mon_en = 1'b0;
   logic prev_req = 1'b0;

   // Bench-side expectation state: tick reference cycle, ticks since, seconds of day, sync count.
   int   m_base = 0;
   int   m_k = 0;
   int   m_tot = 0;
   int   m_cnt = 0;
   bit   m_req = 1'b0;

   time_keeper_if tk_if ();

   time_keeper #(
      .CLK_DIV        (4),
      .SYNC_PERIOD_S  (10),
      .SYNC_TIMEOUT_S (3)
   ) dut (
      .clock (clk),
      .reset (reset),
      .tk    (tk_if)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic void push(ev_kind_e k, int c, int t);
      exp_q.push_back('{k, c, t / 3600, (t / 60) % 60, t % 60});
   endfunction

   task automatic chk(string name, int act, int exp);
      n_checks++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
   endtask

   task automatic see(ev_kind_e k);
      ev_t e;
      n_checks++;
      if (exp_q.size() == 0) begin
         $display("FAIL event %s at cycle %0d: none expected", k.name(), cyc);
         return;
      end
      e = exp_q.pop_front();
      if (e.kind == k && e.cyc == cyc && e.hr == int'(tk_if.hr) &&
          e.mn == int'(tk_if.min) && e.sc == int'(tk_if.sec)) begin
         n_pass++;
      end else begin
         $display("FAIL event: got %s @%0d %0d:%0d:%0d, expected %s @%0d %0d:%0d:%0d",
                  k.name(), cyc, tk_if.hr, tk_if.min, tk_if.sec,
                  e.kind.name(), e.cyc, e.hr, e.mn, e.sc);
      end
   endtask

   // Monitor: fixed event order per cycle matches the order the stimulus side pushes them.
   always @(negedge clk) begin
      if (mon_en) begin
         if (tk_if.request !== prev_req) see(tk_if.request ? EV_REQ_RISE : EV_REQ_FALL);
         prev_req = tk_if.request;
         if (tk_if.sync_fail) see(EV_FAIL);
         if (tk_if.load_err)  see(EV_LERR);
         if (tk_if.sec_tick)  see(EV_TICK);
      end
   end

   // One expected tick with resulting time new_tot, plus any sync request/timeout it causes.
   task automatic model_tick(int new_tot);
      m_k++;
      m_cnt++;
      if (!m_req && m_cnt == 10) begin
         push(EV_REQ_RISE, m_base + 4 * m_k, new_tot);
         m_req = 1'b1;
         m_cnt = 0;
      end else if (m_req && m_cnt == 3) begin
         push(EV_REQ_FALL, m_base + 4 * m_k, new_tot);
         push(EV_FAIL, m_base + 4 * m_k, new_tot);
         m_req = 1'b0;
         m_cnt = 0;
      end
      push(EV_TICK, m_base + 4 * m_k, new_tot);
      m_tot = new_tot;
   endtask

   task automatic wait_to(int c);
      while (cyc < c) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic run_ticks(int n);
      for (int i = 0; i < n; i++) model_tick((m_tot + 1) % 86400);
      wait_to(m_base + 4 * m_k);
   endtask

   task automatic chk_time(string name, int t);
      chk({name, "_hr"},  int'(tk_if.hr),  t / 3600);
      chk({name, "_min"}, int'(tk_if.min), (t / 60) % 60);
      chk({name, "_sec"}, int'(tk_if.sec), t % 60);
   endtask

   // Two reset edges; optionally sync_done (12:34:56) is high on the first one.
   task automatic do_reset(bit with_sync);
      reset            = 1'b1;
      tk_if.sync_done  = with_sync;
      tk_if.sync_hr    = 5'd12;
      tk_if.sync_min   = 6'd34;
      tk_if.sync_sec   = 6'd56;
      tk_if.inc_hr     = 1'b0;
      tk_if.inc_min    = 1'b0;
      if (m_req) push(EV_REQ_FALL, cyc + 1, 0);
      @(posedge clk);
      #1;
      mon_en          = 1'b1;
      tk_if.sync_done = 1'b0;
      @(posedge clk);
      #1;
      reset  = 1'b0;
      m_base = cyc;
      m_k    = 0;
      m_tot  = 0;
      m_cnt  = 0;
      m_req  = 1'b0;
      chk_time("rst", 0);
      chk("rst_sec_tick",  int'(tk_if.sec_tick),  0);
      chk("rst_request",   int'(tk_if.request),   0);
      chk("rst_sync_fail", int'(tk_if.sync_fail), 0);
      chk("rst_load_err",  int'(tk_if.load_err),  0);
   endtask

   // One-cycle sync_done; valid loads restart the tick phase and the sync count.
   task automatic do_load(int h, int m, int s);
      bit ok;
      ok = (h <= 23) && (m <= 59) && (s <= 59);
      tk_if.sync_hr   = 5'(h);
      tk_if.sync_min  = 6'(m);
      tk_if.sync_sec  = 6'(s);
      tk_if.sync_done = 1'b1;
      if (ok && m_req) push(EV_REQ_FALL, cyc + 1, h * 3600 + m * 60 + s);
      if (!ok) push(EV_LERR, cyc + 1, m_tot);
      @(posedge clk);
      #1;
      tk_if.sync_done = 1'b0;
      if (ok) begin
         m_base = cyc;
         m_k    = 0;
         m_cnt  = 0;
         m_req  = 1'b0;
         m_tot  = h * 3600 + m * 60 + s;
      end
      chk_time("load", m_tot);
      chk("load_request", int'(tk_if.request), int'(m_req));
   endtask

   // Adjust pulse away from any tick; expected result given by hand.
   task automatic pulse_inc(bit ih, bit im, int eh, int em, int es);
      tk_if.inc_hr  = ih;
      tk_if.inc_min = im;
      @(posedge clk);
      #1;
      tk_if.inc_hr  = 1'b0;
      tk_if.inc_min = 1'b0;
      m_tot = eh * 3600 + em * 60 + es;
      chk_time("adj", m_tot);
   endtask

   // Adjust pulse sampled on the same edge as the next tick; expected result given by hand.
   task automatic tick_adjust(bit ih, bit im, int eh, int em, int es);
      int tgt;
      tgt = m_base + 4 * (m_k + 1);
      wait_to(tgt - 1);
      tk_if.inc_hr  = ih;
      tk_if.inc_min = im;
      model_tick(eh * 3600 + em * 60 + es);
      @(posedge clk);
      #1;
      tk_if.inc_hr  = 1'b0;
      tk_if.inc_min = 1'b0;
   endtask

   initial begin
      // 1: free run, periodic requests/timeouts, wrap at midnight
      do_reset(1'b0);
      run_ticks(60);
      chk_time("t1_run", 60);
      do_load(23, 59, 59);
      run_ticks(1);

      // 2: request at tick 10, timeout after 3 more ticks
      do_reset(1'b0);
      run_ticks(10);
      chk("t2_req_high", int'(tk_if.request), 1);
      run_ticks(3);
      chk("t2_req_low", int'(tk_if.request), 0);
      chk_time("t2", 13);

      // 3: valid load in REQ_WAIT ends the request and restarts the second
      do_reset(1'b0);
      run_ticks(11);
      do_load(12, 34, 56);
      run_ticks(1);

      // 4: out-of-range load leaves time and request alone
      do_reset(1'b0);
      run_ticks(10);
      do_load(5, 6, 60);
      run_ticks(2);
      chk("t4_req_held", int'(tk_if.request), 1);
      run_ticks(1);
      chk("t4_req_timeout", int'(tk_if.request), 0);

      // 5: adjusts, including inc_min on a carrying tick
      do_reset(1'b0);
      do_load(0, 59, 59);
      tick_adjust(1'b0, 1'b1, 1, 1, 0);
      do_load(23, 15, 30);
      pulse_inc(1'b1, 1'b0, 0, 15, 30);
      run_ticks(1);
      do_load(7, 59, 10);
      pulse_inc(1'b0, 1'b1, 7, 0, 10);

      // 6: reset in REQ_WAIT with sync_done high wins over the load
      do_reset(1'b0);
      run_ticks(10);
      do_reset(1'b1);
      run_ticks(2);

      repeat (3) @(posedge clk);
      #1;
      n_checks++;
      if (exp_q.size() == 0) n_pass++;
      else $display("FAIL leftover_events: got %0d pending, expected 0", exp_q.size());

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
